// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and signed range helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package alu_pkg;

  // Add/subtract select as carried on the in_sub / op lines
  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } aluOp_e;

  // Widest operand the range helpers can describe
  localparam int ALU_MAX_WIDTH = 64;

  // Largest positive two's-complement value for a given width, zero-extended
  function automatic logic [ALU_MAX_WIDTH-1:0] signedMax(input int width);
    signedMax = (ALU_MAX_WIDTH'(1) << (width - 1)) - ALU_MAX_WIDTH'(1);
  endfunction

  // Most negative two's-complement value for a given width, zero-extended
  function automatic logic [ALU_MAX_WIDTH-1:0] signedMin(input int width);
    signedMin = ALU_MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational signed adder with overflow detect, optional saturation and status flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller owns all handshaking.
module addsub_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] bEff,
  input  logic             cin,
  input  logic             sat,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             carry,
  output logic             zero,
  output logic             neg
);

  localparam int MSB = WIDTH - 1;
  localparam logic [ALU_MAX_WIDTH-1:0] MAX_FULL = signedMax(WIDTH);
  localparam logic [ALU_MAX_WIDTH-1:0] MIN_FULL = signedMin(WIDTH);
  localparam logic [WIDTH-1:0]         MAX_VAL  = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]         MIN_VAL  = MIN_FULL[WIDTH-1:0];

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;
  logic             satEff;

  // Extended adder: the extra top bit is the unsigned carry / not-borrow
  always_comb begin
    sum = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, cin};
  end

  assign raw   = sum[WIDTH-1:0];
  assign carry = sum[WIDTH];

  // Signed overflow: both addends share a sign that the sum does not
  assign ovf = (~raw[MSB] &  a[MSB] &  bEff[MSB]) |
               ( raw[MSB] & ~a[MSB] & ~bEff[MSB]);

  // Saturation only exists when the build enables it
  assign satEff = SAT_EN & sat;

  // Clamp toward the operand A sign on overflow, else pass the raw sum
  always_comb begin
    result = raw;
    if (satEff && ovf) begin
      result = a[MSB] ? MIN_VAL : MAX_VAL;
    end
  end

  // Zero and negative describe what the consumer actually receives
  assign zero = (result == '0);
  assign neg  = result[MSB];

endmodule

// File: rtl/alu_addsub_pipe.sv
// Two-stage pipelined signed add/subtract with flags, optional saturation and overflow tracking.
// Latency: 2 cycles from input handshake to output valid; 1 beat/cycle throughput.
// Backpressure: valid/ready; two beats buffered under full stall, then in_ready drops.
module alu_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SAT_EN    = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_sub,
  input  logic                 in_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_ovf,
  output logic                 out_carry,
  output logic                 out_zero,
  output logic                 out_neg,
  input  logic                 clr_sticky,
  output logic                 sticky_ovf,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  aluOp_e           op;
  logic [WIDTH-1:0] bIn;

  // Stage 1 registers: operands with B already conditioned for the op
  logic             valid1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] bEff1;
  logic             cin1;
  logic             sat1;

  // Stage 2 is the output register set
  logic             valid2;

  logic [WIDTH-1:0] coreResult;
  logic             coreOvf;
  logic             coreCarry;
  logic             coreZero;
  logic             coreNeg;

  logic             adv2;
  logic             ovfEvent;

  // Subtract is A + ~B + 1, so fold the inversion in before registering
  assign op  = aluOp_e'(in_sub);
  assign bIn = (op == ALU_OP_SUB) ? ~in_b : in_b;

  // Stage 2 may take a new beat when empty or when its beat is leaving
  assign adv2     = ~valid2 | out_ready;
  assign in_ready = ~valid1 | adv2;

  // Stage 1 capture on input handshake; holds while stage 2 is stalled
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid1 <= 1'b0;
      a1     <= '0;
      bEff1  <= '0;
      cin1   <= 1'b0;
      sat1   <= 1'b0;
    end else if (in_ready) begin
      valid1 <= in_valid;
      if (in_valid) begin
        a1    <= in_a;
        bEff1 <= bIn;
        cin1  <= (op == ALU_OP_SUB);
        sat1  <= in_sat;
      end
    end
  end

  addsub_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN != 0)
  ) u_core (
    .a      (a1),
    .bEff   (bEff1),
    .cin    (cin1),
    .sat    (sat1),
    .result (coreResult),
    .ovf    (coreOvf),
    .carry  (coreCarry),
    .zero   (coreZero),
    .neg    (coreNeg)
  );

  // Stage 2 registers the computed result and flags when it can advance
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid2     <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
    end else if (adv2) begin
      valid2 <= valid1;
      if (valid1) begin
        out_result <= coreResult;
        out_ovf    <= coreOvf;
        out_carry  <= coreCarry;
        out_zero   <= coreZero;
        out_neg    <= coreNeg;
      end
    end
  end

  assign out_valid = valid2;

  // An overflow is only counted once the consumer actually takes the beat
  assign ovfEvent = valid2 & out_ready & out_ovf;

  // Sticky flag: a coincident event beats the clear
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sticky_ovf <= 1'b0;
    end else if (ovfEvent) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

  // Saturating event counter; clear plus event restarts the count at one
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (ovfEvent) begin
      if (clr_sticky) begin
        ovf_count <= CNT_WIDTH'(1);
      end else if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_WIDTH'(1);
      end
    end else if (clr_sticky) begin
      ovf_count <= '0;
    end
  end

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Self-checking bench for alu_addsub_pipe: directed corner beats plus randomized stream.
// Expected results come from a signed-integer arithmetic model of the operation.
// Stalls are exercised with both fixed and random out_ready patterns.
module tb_alu_addsub_pipe;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 2;
  localparam longint SMAX  = 64'sd2147483647;
  localparam longint SMIN  = -64'sd2147483648;
  localparam longint UMAX  = 64'sd4294967295;

  typedef struct packed {
    logic [31:0] r;
    logic        ovf;
    logic        carry;
    logic        zero;
    logic        neg;
  } beat_t;

  logic                 clock;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_sub;
  logic                 in_sat;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_ovf;
  logic                 out_carry;
  logic                 out_zero;
  logic                 out_neg;
  logic                 clr_sticky;
  logic                 sticky_ovf;
  logic [CNT_WIDTH-1:0] ovf_count;

  int    nVec = 0;
  int    nErr = 0;
  beat_t expQ[$];

  alu_addsub_pipe #(
    .WIDTH     (WIDTH),
    .SAT_EN    (1),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .in_sat     (in_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .ovf_count  (ovf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact signed math, then clamp or wrap
  function automatic beat_t refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic sub, input logic sat);
    beat_t  e;
    longint sa, sb, t, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    t  = sub ? (sa - sb) : (sa + sb);
    e.ovf = (t > SMAX) || (t < SMIN);
    if (e.ovf && sat) e.r = (t > 0) ? 32'h7FFFFFFF : 32'h80000000;
    else              e.r = t[31:0];
    e.carry = sub ? (ua >= ub) : ((ua + ub) > UMAX);
    e.zero  = (e.r == 32'h0);
    e.neg   = e.r[31];
    return e;
  endfunction

  function automatic logic [31:0] pickOp();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'h00000000;
      3:       return 32'hFFFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  // Single beat with out_ready held high; returns captured output and latency in cycles
  task automatic runBeat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic sat, input logic clrOnOut,
                         output beat_t got, output int lat);
    @(negedge clock);
    clr_sticky = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_a = a; in_b = b; in_sub = sub; in_sat = sat;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    got = {out_result, out_ovf, out_carry, out_zero, out_neg};
    clr_sticky = clrOnOut;
  endtask

  task automatic test_reset;
    logic [39:0] snap;
    reset_n = 1'b0; in_valid = 1'b1; in_a = 32'h7FFFFFFF; in_b = 32'h1;
    in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (2) @(negedge clock);
    snap = {out_valid, out_result, out_ovf, out_carry, out_zero, out_neg, sticky_ovf, ovf_count};
    nVec++;
    if (snap !== 40'h0) begin nErr++; $display("FAIL reset_outputs got=%h want=0", snap); end
    in_valid = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    nVec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nErr++; $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    // load a beat under stall, then reset while it is in flight
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    nVec++;
    if (out_valid !== 1'b1) begin nErr++; $display("FAIL preflush_valid got=%b want=1", out_valid); end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    nVec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
      nErr++; $display("FAIL flush out_valid=%b in_ready=%b result=%h want 0/1/0", out_valid, in_ready, out_result);
    end
    @(negedge clock);
    nVec++;
    if (out_valid !== 1'b0) begin nErr++; $display("FAIL flush_drained out_valid=%b want=0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_add_ovf;
    beat_t got, want;
    int    lat;
    runBeat(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, got, lat);
    nVec++;
    if (lat !== 2) begin nErr++; $display("FAIL add_latency got=%0d want=2", lat); end
    want = {32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1};
    nVec++;
    if (got !== want) begin nErr++; $display("FAIL add_ovf got=%h want=%h", got, want); end
    @(negedge clock);
    nVec++;
    if (sticky_ovf !== 1'b1 || ovf_count !== 2'd1) begin
      nErr++; $display("FAIL add_ovf_track sticky=%b count=%0d want 1/1", sticky_ovf, ovf_count);
    end
  endtask

  task automatic test_clear;
    @(negedge clock); clr_sticky = 1'b1;
    @(negedge clock); clr_sticky = 1'b0;
    nVec++;
    if (sticky_ovf !== 1'b0 || ovf_count !== 2'd0) begin
      nErr++; $display("FAIL clear sticky=%b count=%0d want 0/0", sticky_ovf, ovf_count);
    end
  endtask

  task automatic test_saturate;
    beat_t got, want;
    int    lat;
    runBeat(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, got, lat);
    want = {32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    nVec++;
    if (got !== want) begin nErr++; $display("FAIL sat_pos got=%h want=%h", got, want); end
    runBeat(32'h80000000, 32'h1, 1'b1, 1'b1, 1'b0, got, lat);
    want = {32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
    nVec++;
    if (got !== want) begin nErr++; $display("FAIL sat_neg got=%h want=%h", got, want); end
    runBeat(32'h80000000, 32'h1, 1'b1, 1'b0, 1'b0, got, lat);
    want = {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    nVec++;
    if (got !== want) begin nErr++; $display("FAIL sub_wrap got=%h want=%h", got, want); end
  endtask

  task automatic test_sub_flags;
    beat_t got, want;
    int    lat;
    runBeat(32'd5, 32'd5, 1'b1, 1'b0, 1'b0, got, lat);
    want = {32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    nVec++;
    if (got !== want) begin nErr++; $display("FAIL sub_zero got=%h want=%h", got, want); end
    runBeat(32'd3, 32'd5, 1'b1, 1'b0, 1'b0, got, lat);
    want = {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    nVec++;
    if (got !== want) begin nErr++; $display("FAIL sub_borrow got=%h want=%h", got, want); end
  endtask

  task automatic test_backpressure;
    logic [31:0] aArr[4], bArr[4];
    logic        sArr[4], tArr[4];
    beat_t       got, want;
    int          sent = 0, recv = 0, cyc = 0;
    for (int i = 0; i < 4; i++) begin
      aArr[i] = pickOp(); bArr[i] = pickOp();
      sArr[i] = 1'($urandom_range(0, 1)); tArr[i] = 1'($urandom_range(0, 1));
    end
    while (recv < 4 && cyc < 40) begin
      @(negedge clock);
      clr_sticky = 1'b0;
      in_valid   = (sent < 4);
      if (sent < 4) begin
        in_a = aArr[sent]; in_b = bArr[sent]; in_sub = sArr[sent]; in_sat = tArr[sent];
      end
      out_ready = (cyc >= 5);
      #1;
      if (out_valid && out_ready) begin
        got = {out_result, out_ovf, out_carry, out_zero, out_neg};
        want = expQ.pop_front();
        recv++;
        nVec++;
        if (got !== want) begin nErr++; $display("FAIL bp_beat%0d got=%h want=%h", recv - 1, got, want); end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refModel(in_a, in_b, in_sub, in_sat));
        sent++;
      end
      if (cyc == 4) begin
        nVec++;
        if (sent !== 2 || in_ready !== 1'b0) begin
          nErr++; $display("FAIL bp_stall accepted=%0d in_ready=%b want 2/0", sent, in_ready);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    nVec++;
    if (recv !== 4) begin nErr++; $display("FAIL bp_delivered got=%0d want=4", recv); end
  endtask

  task automatic test_counter;
    beat_t got, want;
    int    lat;
    test_clear();
    want = {32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      runBeat(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, got, lat);
      nVec++;
      if (got !== want) begin nErr++; $display("FAIL cnt_beat%0d got=%h want=%h", i, got, want); end
    end
    @(negedge clock);
    nVec++;
    if (sticky_ovf !== 1'b1 || ovf_count !== 2'd3) begin
      nErr++; $display("FAIL cnt_saturate sticky=%b count=%0d want 1/3", sticky_ovf, ovf_count);
    end
    runBeat(32'h80000000, 32'h1, 1'b1, 1'b0, 1'b1, got, lat);
    @(negedge clock);
    clr_sticky = 1'b0;
    nVec++;
    if (sticky_ovf !== 1'b1 || ovf_count !== 2'd1) begin
      nErr++; $display("FAIL cnt_clr_vs_event sticky=%b count=%0d want 1/1", sticky_ovf, ovf_count);
    end
    test_clear();
  endtask

  task automatic test_random;
    localparam int N = 120;
    logic [31:0] aArr[N], bArr[N];
    logic        sArr[N], tArr[N];
    beat_t       got, want;
    int          sent = 0, recv = 0, cyc = 0, mCount = 0;
    logic        mSticky = 1'b0, holding = 1'b0;
    for (int i = 0; i < N; i++) begin
      aArr[i] = pickOp(); bArr[i] = pickOp();
      sArr[i] = 1'($urandom_range(0, 1)); tArr[i] = 1'($urandom_range(0, 1));
    end
    while ((sent < N || recv < sent) && cyc < 2000) begin
      @(negedge clock);
      clr_sticky = 1'b0;
      in_valid = (sent < N) && (holding || ($urandom_range(0, 99) < 70));
      if (sent < N) begin
        in_a = aArr[sent]; in_b = bArr[sent]; in_sub = sArr[sent]; in_sat = tArr[sent];
      end
      out_ready = (sent >= N) ? 1'b1 : ($urandom_range(0, 99) < 60);
      #1;
      if (out_valid && out_ready) begin
        got = {out_result, out_ovf, out_carry, out_zero, out_neg};
        recv++;
        nVec++;
        if (expQ.size() == 0) begin
          nErr++; $display("FAIL rnd_extra got=%h want=none", got);
        end else begin
          want = expQ.pop_front();
          if (got !== want) begin nErr++; $display("FAIL rnd_beat%0d got=%h want=%h", recv - 1, got, want); end
          if (want.ovf) begin
            mSticky = 1'b1;
            if (mCount < 3) mCount++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refModel(in_a, in_b, in_sub, in_sat));
        sent++;
        holding = 1'b0;
      end else begin
        holding = in_valid;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    nVec++;
    if (sent !== N || recv !== N) begin
      nErr++; $display("FAIL rnd_complete sent=%0d recv=%0d want %0d/%0d", sent, recv, N, N);
    end
    @(negedge clock);
    nVec++;
    if (sticky_ovf !== mSticky || ovf_count !== 2'(mCount)) begin
      nErr++; $display("FAIL rnd_track sticky=%b count=%0d want %b/%0d", sticky_ovf, ovf_count, mSticky, mCount);
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_clear();
    test_saturate();
    test_sub_flags();
    test_backpressure();
    test_counter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
